// File: rtl/logic_gate_pkg.sv
// logic_gate_pkg: operation encoding shared by the reduction and the pipeline.
// Rev 1.0
`default_nettype none

package logic_gate_pkg;

   localparam int MODE_W = 3;

   typedef enum logic [MODE_W-1:0] {
      MODE_AND  = 3'd0,
      MODE_OR   = 3'd1,
      MODE_XOR  = 3'd2,
      MODE_NAND = 3'd3,
      MODE_NOR  = 3'd4,
      MODE_XNOR = 3'd5,
      MODE_PASS = 3'd6,
      MODE_RSVD = 3'd7
   } gate_mode_e;

   localparam logic [MODE_W-1:0] RESERVED_MODE = MODE_RSVD;

endpackage

`default_nettype wire

// File: rtl/gate_reduce.sv
// gate_reduce: per-bit AND/OR/XOR family reduction across NUM_IN channels.
// Rev 1.0
`default_nettype none

module gate_reduce
   import logic_gate_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int NUM_IN = 4
) (
   input  logic [NUM_IN*WIDTH-1:0] i_data,
   input  logic [MODE_W-1:0]       i_mode,
   output logic [WIDTH-1:0]        o_result,
   output logic                    o_err
);

   logic [WIDTH-1:0] w_and;
   logic [WIDTH-1:0] w_or;
   logic [WIDTH-1:0] w_xor;

   always_comb begin
      w_and = '1;
      w_or  = '0;
      w_xor = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         w_and = w_and & i_data[k*WIDTH +: WIDTH];
         w_or  = w_or  | i_data[k*WIDTH +: WIDTH];
         w_xor = w_xor ^ i_data[k*WIDTH +: WIDTH];
      end
   end

   // The reserved encoding yields a zero result flagged as an error.
   always_comb begin
      o_result = '0;
      o_err    = 1'b0;
      case (gate_mode_e'(i_mode))
         MODE_AND:  o_result = w_and;
         MODE_OR:   o_result = w_or;
         MODE_XOR:  o_result = w_xor;
         MODE_NAND: o_result = ~w_and;
         MODE_NOR:  o_result = ~w_or;
         MODE_XNOR: o_result = ~w_xor;
         MODE_PASS: o_result = i_data[WIDTH-1:0];
         default: begin
            o_result = '0;
            o_err    = 1'b1;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: two-stage valid/ready pipeline around gate_reduce with a
// saturating output-transfer counter. Rev 1.0
`default_nettype none

module logic_gate_pipe
   import logic_gate_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int NUM_IN = 4,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] i_in_data,
   input  logic [MODE_W-1:0]       i_mode,
   input  logic                    i_in_valid,
   output logic                    o_in_ready,
   output logic [WIDTH-1:0]        o_out_data,
   output logic                    o_out_err,
   output logic                    o_out_valid,
   input  logic                    i_out_ready,
   input  logic                    i_cnt_clr,
   output logic [CNT_W-1:0]        o_txn_cnt
);

   logic                    r_s1_valid;
   logic [NUM_IN*WIDTH-1:0] r_s1_data;
   logic [MODE_W-1:0]       r_s1_mode;
   logic                    r_s2_valid;
   logic [WIDTH-1:0]        r_s2_data;
   logic                    r_s2_err;
   logic [CNT_W-1:0]        r_txn_cnt;

   logic [WIDTH-1:0]        w_result;
   logic                    w_err;
   logic                    w_s2_load;
   logic                    w_s1_load;
   logic                    w_out_xfer;

   gate_reduce #(
      .WIDTH  (WIDTH),
      .NUM_IN (NUM_IN)
   ) u_reduce (
      .i_data   (r_s1_data),
      .i_mode   (r_s1_mode),
      .o_result (w_result),
      .o_err    (w_err)
   );

   // S1 may load whenever S2 can make room, so ready never looks at i_in_valid.
   assign w_s2_load  = !r_s2_valid || i_out_ready;
   assign w_s1_load  = !r_s1_valid || w_s2_load;
   assign w_out_xfer = r_s2_valid && i_out_ready;

   assign o_in_ready  = w_s1_load;
   assign o_out_valid = r_s2_valid;
   assign o_out_data  = r_s2_data;
   assign o_out_err   = r_s2_err;
   assign o_txn_cnt   = r_txn_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_data  <= '0;
         r_s1_mode  <= '0;
      end else if (w_s1_load) begin
         r_s1_valid <= i_in_valid;
         if (i_in_valid) begin
            r_s1_data <= i_in_data;
            r_s1_mode <= i_mode;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_s2_data  <= '0;
         r_s2_err   <= 1'b0;
      end else if (w_s2_load) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_data <= w_result;
            r_s2_err  <= w_err;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_txn_cnt <= '0;
      end else if (i_cnt_clr) begin
         r_txn_cnt <= '0;
      end else if (w_out_xfer && (r_txn_cnt != '1)) begin
         r_txn_cnt <= r_txn_cnt + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_logic_gate_pipe.sv
// tb_logic_gate_pipe: directed and randomized checks of logic_gate_pipe
// against a bit-counting reference model. Rev 1.0
`default_nettype none

module tb_logic_gate_pipe;

   localparam int WIDTH  = 8;
   localparam int NUM_IN = 4;
   localparam int CNT_W  = 16;
   localparam logic [31:0] CHANNELS = 32'hFF55_330F;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] i_in_data = '0;
   logic [2:0]  i_mode = '0;
   logic        i_in_valid = 1'b0;
   logic        o_in_ready;
   logic [7:0]  o_out_data;
   logic        o_out_err;
   logic        o_out_valid;
   logic        i_out_ready = 1'b0;
   logic        i_cnt_clr = 1'b0;
   logic [15:0] o_txn_cnt;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [8:0] exp_q[$];

   always #5 clk = ~clk;

   logic_gate_pipe #(
      .WIDTH  (WIDTH),
      .NUM_IN (NUM_IN),
      .CNT_W  (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_in_data   (i_in_data),
      .i_mode      (i_mode),
      .i_in_valid  (i_in_valid),
      .o_in_ready  (o_in_ready),
      .o_out_data  (o_out_data),
      .o_out_err   (o_out_err),
      .o_out_valid (o_out_valid),
      .i_out_ready (i_out_ready),
      .i_cnt_clr   (i_cnt_clr),
      .o_txn_cnt   (o_txn_cnt)
   );

   // Reference: count ones per bit column and decide from the count.
   function automatic logic [8:0] model(input logic [31:0] d, input logic [2:0] m);
      logic [7:0] r;
      int ones;
      for (int i = 0; i < 8; i++) begin
         ones = 0;
         for (int k = 0; k < 4; k++) ones += int'(d[k*8 + i]);
         case (m)
            3'd0: r[i] = (ones == 4);
            3'd1: r[i] = (ones > 0);
            3'd2: r[i] = (ones % 2 == 1);
            3'd3: r[i] = !(ones == 4);
            3'd4: r[i] = (ones == 0);
            3'd5: r[i] = (ones % 2 == 0);
            3'd6: r[i] = d[i];
            default: r[i] = 1'b0;
         endcase
      end
      return {(m == 3'd7), r};
   endfunction

   // Called just after a falling edge: applies inputs, samples the settled
   // pre-edge view, then advances through one rising edge to the next fall.
   task automatic drive_cycle(input logic v, input logic [31:0] d, input logic [2:0] m,
                              input logic ordy, input logic clr,
                              output logic ix, output logic ox, output logic ov,
                              output logic ir, output logic [7:0] od, output logic oe,
                              output logic [15:0] oc);
      i_in_valid  = v;
      i_in_data   = d;
      i_mode      = m;
      i_out_ready = ordy;
      i_cnt_clr   = clr;
      #1;
      ir = o_in_ready;
      ov = o_out_valid;
      ix = v && o_in_ready;
      ox = o_out_valid && ordy;
      od = o_out_data;
      oe = o_out_err;
      oc = o_txn_cnt;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (o_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", o_in_ready); end
      n_cmp++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", o_out_valid); end
      n_cmp++; if (o_out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00", o_out_data); end
      n_cmp++; if (o_out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err: got %b expected 0", o_out_err); end
      n_cmp++; if (o_txn_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_txn_cnt: got %0d expected 0", o_txn_cnt); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_cmp++; if (o_in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b expected 1", o_in_ready); end
      @(negedge clk);
   endtask

   // Four modes back-to-back on the fixed channel set; results expected on
   // pre-edge samples 2..5 after the first transfer at sample 0.
   task automatic test_modes(input logic [2:0] modes[4], input logic [8:0] expv[4]);
      logic ix, ox, ov, ir, oe;
      logic [7:0] od;
      logic [15:0] oc;
      logic [2:0] m;
      for (int c = 0; c < 8; c++) begin
         m = 3'd0;
         if (c < 4) m = modes[c];
         drive_cycle(c < 4, CHANNELS, m, 1'b1, 1'b0, ix, ox, ov, ir, od, oe, oc);
         if (c < 4) begin
            n_cmp++; if (ix !== 1'b1) begin n_fail++; $display("FAIL modes_accept[%0d]: got %b expected 1", c, ix); end
         end
         if (c >= 2 && c < 6) begin
            n_cmp++; if (ov !== 1'b1) begin n_fail++; $display("FAIL modes_valid[%0d]: got %b expected 1", c, ov); end
            n_cmp++; if (od !== expv[c-2][7:0]) begin n_fail++; $display("FAIL modes_data[%0d] mode %0d: got %h expected %h", c, modes[c-2], od, expv[c-2][7:0]); end
            n_cmp++; if (oe !== expv[c-2][8]) begin n_fail++; $display("FAIL modes_err[%0d] mode %0d: got %b expected %b", c, modes[c-2], oe, expv[c-2][8]); end
         end else begin
            n_cmp++; if (ov !== 1'b0) begin n_fail++; $display("FAIL modes_idle_valid[%0d]: got %b expected 0", c, ov); end
         end
      end
   endtask

   task automatic test_basic_modes;
      logic [2:0] modes[4];
      logic [8:0] expv[4];
      modes = '{3'd0, 3'd1, 3'd2, 3'd6};
      expv  = '{9'h001, 9'h0FF, 9'h096, 9'h00F};
      test_modes(modes, expv);
   endtask

   task automatic test_inverted_modes;
      logic [2:0] modes[4];
      logic [8:0] expv[4];
      modes = '{3'd3, 3'd4, 3'd5, 3'd7};
      expv  = '{9'h0FE, 9'h000, 9'h069, 9'h100};
      test_modes(modes, expv);
   endtask

   task automatic test_backpressure;
      logic ix, ox, ov, ir, oe;
      logic [7:0] od;
      logic [15:0] oc;
      logic [31:0] d;
      logic [2:0] m;
      logic [8:0] got;
      int acc = 0;
      int outs = 0;
      for (int c = 0; c < 5; c++) begin
         d = $urandom;
         m = 3'($urandom_range(0, 6));
         drive_cycle(1'b1, d, m, 1'b0, 1'b0, ix, ox, ov, ir, od, oe, oc);
         if (ix) begin exp_q.push_back(model(d, m)); acc++; end
         if (c >= 2) begin
            n_cmp++; if (ir !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", c, ir); end
            n_cmp++; if (ov !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", c, ov); end
            n_cmp++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_hold[%0d]: got %h expected a queued result", c, {oe, od}); end
            else if ({oe, od} !== exp_q[0]) begin n_fail++; $display("FAIL bp_hold[%0d]: got %h expected %h", c, {oe, od}, exp_q[0]); end
         end
      end
      n_cmp++; if (acc != 2) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 2", acc); end
      for (int c = 0; c < 6; c++) begin
         drive_cycle(1'b0, 32'h0, 3'd0, 1'b1, 1'b0, ix, ox, ov, ir, od, oe, oc);
         if (ox) begin
            outs++;
            n_cmp++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_release: got %h expected no output", {oe, od}); end
            else begin
               got = exp_q.pop_front();
               if ({oe, od} !== got) begin n_fail++; $display("FAIL bp_release: got %h expected %h", {oe, od}, got); end
            end
         end
      end
      n_cmp++; if (outs != 2) begin n_fail++; $display("FAIL bp_drained: got %0d expected 2", outs); end
   endtask

   task automatic test_random;
      logic ix, ox, ov, ir, oe, v, r;
      logic [7:0] od;
      logic [15:0] oc;
      logic [31:0] d;
      logic [2:0] m;
      logic [8:0] got, prev;
      logic prev_stall = 1'b0;
      int acc = 0;
      int outs = 0;
      int cyc = 0;
      drive_cycle(1'b0, 32'h0, 3'd0, 1'b0, 1'b1, ix, ox, ov, ir, od, oe, oc);
      n_cmp++; if (oc !== 16'd10) begin n_fail++; $display("FAIL rand_prior_cnt: got %0d expected 10", oc); end
      prev = '0;
      while (outs < 1000 && cyc < 20000) begin
         v = (acc < 1000) && ($urandom_range(0, 9) < 7);
         d = $urandom;
         m = 3'($urandom_range(0, 7));
         r = ($urandom_range(0, 9) < 6);
         drive_cycle(v, d, m, r, 1'b0, ix, ox, ov, ir, od, oe, oc);
         if (prev_stall) begin
            n_cmp++; if ({oe, od} !== prev) begin n_fail++; $display("FAIL rand_stable at cycle %0d: got %h expected %h", cyc, {oe, od}, prev); end
         end
         prev_stall = ov && !r;
         prev = {oe, od};
         if (ix) begin exp_q.push_back(model(d, m)); acc++; end
         if (ox) begin
            outs++;
            n_cmp++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL rand_order: got %h expected no output", {oe, od}); end
            else begin
               got = exp_q.pop_front();
               if ({oe, od} !== got) begin n_fail++; $display("FAIL rand_order #%0d: got %h expected %h", outs, {oe, od}, got); end
            end
         end
         cyc++;
      end
      n_cmp++; if (outs != 1000) begin n_fail++; $display("FAIL rand_timeout: got %0d transfers expected 1000", outs); end
      drive_cycle(1'b0, 32'h0, 3'd0, 1'b1, 1'b0, ix, ox, ov, ir, od, oe, oc);
      n_cmp++; if (oc !== 16'd1000) begin n_fail++; $display("FAIL rand_txn_cnt: got %0d expected 1000", oc); end
      n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_leftover: got %0d queued expected 0", exp_q.size()); end
   endtask

   task automatic test_reset_midflight;
      logic ix, ox, ov, ir, oe;
      logic [7:0] od;
      logic [15:0] oc;
      drive_cycle(1'b1, $urandom, 3'd1, 1'b0, 1'b0, ix, ox, ov, ir, od, oe, oc);
      drive_cycle(1'b1, $urandom, 3'd2, 1'b0, 1'b0, ix, ox, ov, ir, od, oe, oc);
      drive_cycle(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, ix, ox, ov, ir, od, oe, oc);
      n_cmp++; if (ir !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b expected 0", ir); end
      n_cmp++; if (ov !== 1'b1) begin n_fail++; $display("FAIL full_out_valid: got %b expected 1", ov); end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid: got %b expected 0", o_out_valid); end
      n_cmp++; if (o_txn_cnt !== 16'd0) begin n_fail++; $display("FAIL async_rst_cnt: got %0d expected 0", o_txn_cnt); end
      n_cmp++; if (o_in_ready !== 1'b1) begin n_fail++; $display("FAIL async_rst_ready: got %b expected 1", o_in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      for (int c = 0; c < 3; c++) begin
         drive_cycle(1'b0, 32'h0, 3'd0, 1'b1, 1'b0, ix, ox, ov, ir, od, oe, oc);
         n_cmp++; if (ov !== 1'b0) begin n_fail++; $display("FAIL post_rst_valid[%0d]: got %b expected 0", c, ov); end
      end
      drive_cycle(1'b1, CHANNELS, 3'd0, 1'b1, 1'b0, ix, ox, ov, ir, od, oe, oc);
      drive_cycle(1'b1, CHANNELS, 3'd1, 1'b1, 1'b0, ix, ox, ov, ir, od, oe, oc);
      drive_cycle(1'b0, 32'h0, 3'd0, 1'b1, 1'b0, ix, ox, ov, ir, od, oe, oc);
      n_cmp++; if (ox !== 1'b1) begin n_fail++; $display("FAIL clr_first_xfer: got %b expected 1", ox); end
      drive_cycle(1'b0, 32'h0, 3'd0, 1'b1, 1'b1, ix, ox, ov, ir, od, oe, oc);
      n_cmp++; if (ox !== 1'b1) begin n_fail++; $display("FAIL clr_second_xfer: got %b expected 1", ox); end
      n_cmp++; if (oc !== 16'd1) begin n_fail++; $display("FAIL clr_pre_cnt: got %0d expected 1", oc); end
      drive_cycle(1'b0, 32'h0, 3'd0, 1'b1, 1'b0, ix, ox, ov, ir, od, oe, oc);
      n_cmp++; if (oc !== 16'd0) begin n_fail++; $display("FAIL clr_priority_cnt: got %0d expected 0", oc); end
   endtask

   initial begin
      test_reset();
      test_basic_modes();
      test_inverted_modes();
      test_backpressure();
      test_random();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
